// File: rtl/regfile_pkg.sv
// Shared types for the multi-ported register file: dump FSM states and
// the write-port priority resolver used by the write, bypass and busy-clear paths.
package regfile_pkg;

    localparam int DEF_XLEN = 64;
    localparam int MAX_WR   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } dump_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] port;
    } wr_sel_t;

    // Highest-index matching write port wins.
    function automatic wr_sel_t wr_select(input logic [MAX_WR-1:0] match);
        wr_sel_t sel;
        sel = '0;
        for (int unsigned p = 0; p < MAX_WR; p++) begin
            if (match[p]) begin
                sel.hit  = 1'b1;
                sel.port = 2'(p);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared by a valid write
// (set wins on collision), looked up by every read port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int NR_RD  = 2,
    parameter int NR_WR  = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                busy_set_i,
    input  logic [AW-1:0]       busy_addr_i,
    input  logic [NR_WR-1:0]    wr_valid_i,
    input  logic [NR_WR*AW-1:0] wr_addr_i,
    input  logic [NR_RD*AW-1:0] rs_addr_i,
    output logic [NR_RD-1:0]    rs_busy_o
);

    localparam logic [AW:0] NREGS_V = (AW+1)'(NREGS);

    logic [NREGS-1:0] busy_q, busy_d;

    function automatic logic [MAX_WR-1:0] port_match(input logic [NR_WR-1:0]    wv,
                                                     input logic [NR_WR*AW-1:0] wa,
                                                     input logic [AW-1:0]       a);
        logic [MAX_WR-1:0] m;
        m = '0;
        for (int unsigned p = 0; p < NR_WR; p++) begin
            m[p] = wv[p] && (wa[p*AW +: AW] == a);
        end
        return m;
    endfunction

    always_comb begin
        wr_sel_t sel;
        sel    = '0;
        busy_d = busy_q;
        // Entry 0 is never touched, so it stays at its reset value of 0.
        for (int unsigned r = 1; r < NREGS; r++) begin
            sel = wr_select(port_match(wr_valid_i, wr_addr_i, AW'(r)));
            if (sel.hit) begin
                busy_d[r] = 1'b0;
            end
            if (busy_set_i && (busy_addr_i == AW'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    always_comb begin
        logic [AW-1:0] a;
        wr_sel_t       sel;
        a         = '0;
        sel       = '0;
        rs_busy_o = '0;
        for (int unsigned i = 0; i < NR_RD; i++) begin
            a = rs_addr_i[i*AW +: AW];
            if ({1'b0, a} < NREGS_V) begin
                rs_busy_o[i] = busy_q[a];
            end
            if (BYPASS != 0) begin
                sel = wr_select(port_match(wr_valid_i, wr_addr_i, a));
                if (sel.hit) begin
                    rs_busy_o[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported integer register file with write-to-read bypass, busy
// scoreboard and a sequential debug-dump engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREGS  = 32,
    parameter int NR_RD  = 2,
    parameter int NR_WR  = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NR_RD*AW-1:0]   rs_addr,
    output logic [NR_RD*XLEN-1:0] rs_data,
    output logic [NR_RD-1:0]      rs_busy,
    input  logic [NR_WR-1:0]      rd_write,
    input  logic [NR_WR*AW-1:0]   rd_addr,
    input  logic [NR_WR*XLEN-1:0] rd_data,
    input  logic                  busy_set,
    input  logic [AW-1:0]         busy_addr,
    input  logic                  dump_start,
    output logic                  dump_valid,
    output logic [AW-1:0]         dump_idx,
    output logic [XLEN-1:0]       dump_data,
    output logic                  dump_done
);

    localparam logic [AW:0]   NREGS_V  = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS-1);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NR_WR-1:0] wr_valid;
    dump_state_e      state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;

    function automatic logic [MAX_WR-1:0] port_match(input logic [NR_WR-1:0]    wv,
                                                     input logic [NR_WR*AW-1:0] wa,
                                                     input logic [AW-1:0]       a);
        logic [MAX_WR-1:0] m;
        m = '0;
        for (int unsigned p = 0; p < NR_WR; p++) begin
            m[p] = wv[p] && (wa[p*AW +: AW] == a);
        end
        return m;
    endfunction

    // A write is only real if it targets a non-zero, in-range register.
    always_comb begin
        logic [AW-1:0] wa;
        wa       = '0;
        wr_valid = '0;
        for (int unsigned p = 0; p < NR_WR; p++) begin
            wa          = rd_addr[p*AW +: AW];
            wr_valid[p] = rd_write[p] && (wa != '0) && ({1'b0, wa} < NREGS_V);
        end
    end

    always_comb begin
        wr_sel_t sel;
        sel = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            sel = wr_select(port_match(wr_valid, rd_addr, AW'(r)));
            if (sel.hit) begin
                regs_d[r] = rd_data[int'(sel.port)*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        logic [AW-1:0] a;
        wr_sel_t       sel;
        a       = '0;
        sel     = '0;
        rs_data = '0;
        for (int unsigned i = 0; i < NR_RD; i++) begin
            a = rs_addr[i*AW +: AW];
            if ({1'b0, a} < NREGS_V) begin
                rs_data[i*XLEN +: XLEN] = regs_q[a];
            end
            if (BYPASS != 0) begin
                sel = wr_select(port_match(wr_valid, rd_addr, a));
                if (sel.hit) begin
                    rs_data[i*XLEN +: XLEN] = rd_data[int'(sel.port)*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign dump_valid = (state_q == SCAN);
    assign dump_done  = (state_q == DONE);
    assign dump_idx   = idx_q;
    assign dump_data  = (state_q == SCAN) ? regs_q[idx_q] : '0;

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NR_RD  (NR_RD),
        .NR_WR  (NR_WR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk_i       (clk),
        .rst_i       (rst),
        .busy_set_i  (busy_set),
        .busy_addr_i (busy_addr),
        .wr_valid_i  (wr_valid),
        .wr_addr_i   (rd_addr),
        .rs_addr_i   (rs_addr),
        .rs_busy_o   (rs_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: three configurations share stimulus; a per-cycle
// expectation from an array-based model is queued and checked at negedge.
module tb_regfile_mp;

    localparam int XLEN  = 64;
    localparam int AW    = 5;
    localparam int NR_RD = 2;
    localparam int NR_WR = 2;
    localparam int NI    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR_RD*AW-1:0]   rs_addr;
    logic [NR_WR-1:0]      rd_write;
    logic [NR_WR*AW-1:0]   rd_addr;
    logic [NR_WR*XLEN-1:0] rd_data;
    logic                  busy_set;
    logic [AW-1:0]         busy_addr;
    logic                  dump_start;

    logic [NI-1:0][NR_RD*XLEN-1:0] rs_data;
    logic [NI-1:0][NR_RD-1:0]      rs_busy;
    logic [NI-1:0]                 dump_valid, dump_done;
    logic [NI-1:0][AW-1:0]         dump_idx;
    logic [NI-1:0][XLEN-1:0]       dump_data;

    // inst0: 32 regs bypass; inst1: 32 regs no bypass; inst2: 24 regs bypass
    for (genvar g = 0; g < NI; g++) begin : g_dut
        regfile_mp #(
            .XLEN   (XLEN),
            .NREGS  ((g == 2) ? 24 : 32),
            .NR_RD  (NR_RD),
            .NR_WR  (NR_WR),
            .BYPASS ((g == 1) ? 0 : 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .rs_addr    (rs_addr),
            .rs_data    (rs_data[g]),
            .rs_busy    (rs_busy[g]),
            .rd_write   (rd_write),
            .rd_addr    (rd_addr),
            .rd_data    (rd_data),
            .busy_set   (busy_set),
            .busy_addr  (busy_addr),
            .dump_start (dump_start),
            .dump_valid (dump_valid[g]),
            .dump_idx   (dump_idx[g]),
            .dump_data  (dump_data[g]),
            .dump_done  (dump_done[g])
        );
    end

    int nregs [NI] = '{32, 32, 24};
    bit byp   [NI] = '{1'b1, 1'b0, 1'b1};

    logic [XLEN-1:0] mem [NI][64];
    bit              bsy [NI][64];
    int              dpos [NI];   // -1 idle, 0..n-1 scanning entry, n = done pulse

    typedef struct {
        logic [NI-1:0][NR_RD*XLEN-1:0] data;
        logic [NI-1:0][NR_RD-1:0]      busy;
        logic [NI-1:0]                 dv, dn;
        logic [NI-1:0][AW-1:0]         di;
        logic [NI-1:0][XLEN-1:0]       dd;
        bit                            rstchk;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic bit wr_ok(input int k, input int p);
        int a;
        a = int'(rd_addr[p*AW +: AW]);
        return rd_write[p] && (a != 0) && (a < nregs[k]);
    endfunction

    task automatic predict(input bit rc);
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < NR_RD; i++) begin
                int a;
                logic [XLEN-1:0] v;
                bit b;
                a = int'(rs_addr[i*AW +: AW]);
                v = (a != 0 && a < nregs[k]) ? mem[k][a] : '0;
                b = (a < nregs[k]) ? bsy[k][a] : 1'b0;
                if (byp[k]) begin
                    for (int p = 0; p < NR_WR; p++) begin
                        if (wr_ok(k, p) && int'(rd_addr[p*AW +: AW]) == a) begin
                            v = rd_data[p*XLEN +: XLEN];
                            b = 1'b0;
                        end
                    end
                end
                e.data[k][i*XLEN +: XLEN] = v;
                e.busy[k][i] = b;
            end
            e.dv[k] = (dpos[k] >= 0) && (dpos[k] < nregs[k]);
            e.di[k] = AW'(e.dv[k] ? dpos[k] : 0);
            e.dd[k] = e.dv[k] ? mem[k][dpos[k]] : '0;
            e.dn[k] = (dpos[k] == nregs[k]);
        end
        e.rstchk = rc;
        q.push_back(e);
    endtask

    task automatic update();
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                for (int r = 0; r < 64; r++) begin
                    mem[k][r] = '0;
                    bsy[k][r] = 1'b0;
                end
                dpos[k] = -1;
            end else begin
                for (int p = 0; p < NR_WR; p++) begin
                    if (wr_ok(k, p)) begin
                        mem[k][int'(rd_addr[p*AW +: AW])] = rd_data[p*XLEN +: XLEN];
                        bsy[k][int'(rd_addr[p*AW +: AW])] = 1'b0;
                    end
                end
                if (busy_set && busy_addr != 0 && int'(busy_addr) < nregs[k])
                    bsy[k][int'(busy_addr)] = 1'b1;
                if (dpos[k] < 0) begin
                    if (dump_start) dpos[k] = 0;
                end else if (dpos[k] < nregs[k]) begin
                    dpos[k]++;
                end else begin
                    dpos[k] = -1;
                end
            end
        end
    endtask

    task automatic step(input bit chk = 1'b1, input bit rc = 1'b0);
        if (chk) predict(rc);
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic compare(input string nm, input int k, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s inst%0d: got %h expected %h", nm, k, act, expv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < NI; k++) begin
                    compare("rs_data", k, 128'(rs_data[k]), 128'(e.data[k]));
                    compare("rs_busy", k, 128'(rs_busy[k]), 128'(e.busy[k]));
                    compare("dump_valid", k, 128'(dump_valid[k]), 128'(e.dv[k]));
                    compare("dump_done", k, 128'(dump_done[k]), 128'(e.dn[k]));
                    if (e.dv[k]) begin
                        compare("dump_idx", k, 128'(dump_idx[k]), 128'(e.di[k]));
                        compare("dump_data", k, 128'(dump_data[k]), 128'(e.dd[k]));
                    end
                    if (e.rstchk) begin
                        compare("rst_dump_idx", k, 128'(dump_idx[k]), 128'(0));
                        compare("rst_dump_data", k, 128'(dump_data[k]), 128'(0));
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        rs_addr = '0; rd_write = '0; rd_addr = '0; rd_data = '0;
        busy_set = 1'b0; busy_addr = '0; dump_start = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
        rd_write[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
        rd_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input int i, input int a);
        rs_addr[i*AW +: AW] = AW'(a);
    endtask

    initial begin
        bit prev_rst;
        idle_inputs();
        rst = 1'b1;
        step(1'b0); step(1'b0);
        step(1'b1, 1'b1);
        rst = 1'b0;
        step(1'b1, 1'b1);

        // x0 is hardwired zero and never busy
        wr(0, 0, 64'hDEAD); busy_set = 1'b1; busy_addr = '0; rd(0, 0); rd(1, 0);
        step();
        idle_inputs(); rd(0, 0); rd(1, 0);
        step();

        // two ports writing x5: port 1 wins, bypass shows it immediately
        idle_inputs(); wr(0, 5, 64'h11); wr(1, 5, 64'h22); rd(0, 5);
        step();
        idle_inputs(); rd(0, 5); rd(1, 5);
        step();

        // busy x7 at T, write at T+3, then set+write collision
        idle_inputs(); busy_set = 1'b1; busy_addr = 5'd7; rd(0, 7);
        step();
        idle_inputs(); rd(0, 7);
        step(); step();
        wr(0, 7, 64'h77);
        step();
        idle_inputs(); rd(0, 7);
        step();
        busy_set = 1'b1; busy_addr = 5'd7; wr(1, 7, 64'h78);
        step();
        idle_inputs(); rd(0, 7); rd(1, 7);
        step(); step();

        // address 30 is out of range for the 24-entry file
        idle_inputs(); rd(0, 30); rd(1, 30); wr(0, 30, 64'hBAD);
        step();
        idle_inputs(); rd(0, 30); busy_set = 1'b1; busy_addr = 5'd30;
        step();
        idle_inputs(); rd(0, 30);
        step();

        // preload xi = i*3
        for (int i = 1; i < 32; i += 2) begin
            idle_inputs();
            wr(0, i, XLEN'(i * 3));
            if (i + 1 < 32) wr(1, i + 1, XLEN'((i + 1) * 3));
            step();
        end

        // full dump, late write to x4 during idx 4, second start ignored
        idle_inputs(); dump_start = 1'b1;
        step();
        for (int c = 0; c < 36; c++) begin
            idle_inputs();
            dump_start = (c == 10);
            if (c == 4) wr(0, 4, 64'h99);
            rd(0, c % 32); rd(1, 4);
            step();
        end

        // reset at idx 10 aborts the dump without a done pulse
        idle_inputs(); dump_start = 1'b1;
        step();
        idle_inputs();
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(1'b1, 1'b1);
        repeat (40) step();

        // random traffic with occasional resets and dump starts
        prev_rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rs_addr    = (NR_RD*AW)'($urandom);
            rd_write   = NR_WR'($urandom);
            rd_addr    = (c % 2 == 0) ? {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))}
                                      : (NR_WR*AW)'($urandom);
            rd_data    = {$urandom, $urandom, $urandom, $urandom};
            busy_set   = 1'($urandom_range(0, 1));
            busy_addr  = AW'($urandom);
            dump_start = ($urandom_range(0, 40) == 0);
            rst        = ($urandom_range(0, 150) == 0);
            step(1'b1, prev_rst);
            prev_rst = rst;
        end
        rst = 1'b0;
        idle_inputs();
        step(1'b1, prev_rst);
        repeat (3) step();

        @(posedge clk);
        @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
